// File: rtl/cadence_gen.sv
// Cadence square-wave generator: IDLE/HIGH/LOW FSM, period in 2^SHIFT clk units.
// Define CADENCE_JITTER_EN to add LFSR-driven jitter to the LOW phase length.
module cadence_gen #(
  parameter int FAST_SIM = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pedal_en,
  input  logic [7:0] cadence_per,
  output logic       cadence,
  output logic       cadence_rise,
  output logic       pedaling
);

  localparam int SHIFT = (FAST_SIM != 0) ? 7 : 16;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_e;

  state_e      state_q;
  logic [23:0] cnt_q;
  logic [7:0]  per_q;

  logic        valid;
  logic        go;
  logic        enter;
  logic [23:0] h_new;
  logic [23:0] h_cur;
  logic [23:0] low_len;

  assign valid = (cadence_per != 8'h00) && (cadence_per < 8'hE4);
  assign go    = pedal_en & valid;
  assign h_new = {16'h0, cadence_per} << (SHIFT - 1);
  assign h_cur = {16'h0, per_q} << (SHIFT - 1);

  // A new rise happens from IDLE, or at the last LOW clk if still requested
  assign enter = go && ((state_q == IDLE) ||
                        ((state_q == LOW) && (cnt_q == 24'd0)));

`ifdef CADENCE_JITTER_EN
  logic [7:0] lfsr_q;
  logic       lfsr_fb;

  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign low_len = h_cur + ({20'h0, lfsr_q[3:0]} << (SHIFT - 4));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= 8'hA5;
    end else if (enter) begin
      lfsr_q <= {lfsr_q[6:0], lfsr_fb};
    end
  end
`else
  assign low_len = h_cur;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      per_q        <= '0;
      cadence      <= 1'b0;
      cadence_rise <= 1'b0;
      pedaling     <= 1'b0;
    end else begin
      cadence_rise <= 1'b0;
      if (enter) begin
        state_q      <= HIGH;
        per_q        <= cadence_per;
        cnt_q        <= h_new - 24'd1;
        cadence      <= 1'b1;
        cadence_rise <= 1'b1;
        pedaling     <= 1'b1;
      end else begin
        unique case (state_q)
          IDLE: begin
            cadence  <= 1'b0;
            pedaling <= 1'b0;
          end
          HIGH: begin
            if (cnt_q == 24'd0) begin
              state_q <= LOW;
              cadence <= 1'b0;
              cnt_q   <= low_len - 24'd1;
            end else begin
              cnt_q <= cnt_q - 24'd1;
            end
          end
          LOW: begin
            if (cnt_q == 24'd0) begin
              state_q  <= IDLE;
              pedaling <= 1'b0;
            end else begin
              cnt_q <= cnt_q - 24'd1;
            end
          end
          default: begin
            state_q  <= IDLE;
            cadence  <= 1'b0;
            pedaling <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cadence_gen.sv
// Self-checking bench for cadence_gen (FAST_SIM=1): vector table plus
// hand sequences; a negedge monitor measures HIGH/LOW lengths vs a queue.
module tb_cadence_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pedal_en = 1'b0;
  logic [7:0] cadence_per = 8'h00;
  logic       cadence;
  logic       cadence_rise;
  logic       pedaling;

  cadence_gen #(.FAST_SIM(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pedal_en    (pedal_en),
    .cadence_per (cadence_per),
    .cadence     (cadence),
    .cadence_rise(cadence_rise),
    .pedaling    (pedaling)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h;
    int l;
  } exp_t;

  typedef struct {
    logic       en;
    logic [7:0] per;
    int         ncyc;
    int         hlen;
  } vec_t;

  exp_t       q[$];
  vec_t       vecs[8];
  int         tests = 0;
  int         fails = 0;
  int         rise_cnt = 0;
  int         hc = 0;
  int         lc = 0;
  logic       prev_c = 1'b0;
  logic       rst_s = 1'b1;
  logic [7:0] lfsr_m = 8'hA5;

  always @(posedge clk) rst_s <= ~rst_n;

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic push_exp(input int h);
    exp_t e;
    e.h = h;
    e.l = h;
`ifdef CADENCE_JITTER_EN
    lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    e.l = h + int'(lfsr_m[3:0]) * 8;
`endif
    q.push_back(e);
  endtask

  task automatic close_cycle();
    exp_t e;
    if (q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_cycle: high %0d low %0d, none expected", hc, lc);
    end else begin
      e = q.pop_front();
      check("high_len", hc, e.h);
      check("low_len", lc, e.l);
    end
    hc = 0;
    lc = 0;
  endtask

  always @(negedge clk) begin
    if (rst_s) begin
      hc = 0;
      lc = 0;
      prev_c = 1'b0;
    end else begin
      if ((cadence && !prev_c) || cadence_rise) begin
        tests++;
        if (cadence_rise !== (cadence && !prev_c)) begin
          fails++;
          $display("FAIL rise_pulse: rise %b cadence %b prev %b",
                   cadence_rise, cadence, prev_c);
        end
      end
      if (cadence_rise) rise_cnt++;
      if (cadence) begin
        if (lc > 0) close_cycle();
        hc++;
      end else if (pedaling) begin
        lc++;
      end else if (hc > 0 || lc > 0) begin
        close_cycle();
      end
      prev_c = cadence;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    pedal_en = 1'b0;
    cadence_per = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_cadence", int'(cadence), 0);
    check("rst_pedaling", int'(pedaling), 0);
    check("rst_rise", int'(cadence_rise), 0);
    rise_cnt = 0;
    lfsr_m = 8'hA5;
    q.delete();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_rises(input string name, input int n, input int budget);
    for (int k = 0; k < budget && rise_cnt < n; k++) @(negedge clk);
    if (rise_cnt < n) check(name, rise_cnt, n);
  endtask

  task automatic finish_idle(input string name, input int ncyc);
    check({name, "_pedaling"}, int'(pedaling), 0);
    check({name, "_rises"}, rise_cnt, ncyc);
    check({name, "_pending"}, q.size(), 0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 8'h10, 2, 1024};
    vecs[1] = '{1'b1, 8'h08, 2, 512};
    vecs[2] = '{1'b1, 8'h01, 3, 64};
    vecs[3] = '{1'b1, 8'hE3, 1, 14528};
    vecs[4] = '{1'b1, 8'h00, 0, 0};
    vecs[5] = '{1'b1, 8'hE4, 0, 0};
    vecs[6] = '{1'b1, 8'hFF, 0, 0};
    vecs[7] = '{1'b0, 8'h10, 0, 0};

    // First rise one clk after go, then pedal_en dropped inside HIGH
    do_reset();
    push_exp(1024);
    pedal_en = 1'b1;
    cadence_per = 8'h10;
    @(negedge clk);
    check("lat_cadence", int'(cadence), 1);
    check("lat_rise", int'(cadence_rise), 1);
    check("lat_pedaling", int'(pedaling), 1);
    repeat (9) @(negedge clk);
    pedal_en = 1'b0;
    repeat (2048 + 200) @(negedge clk);
    finish_idle("drop_en", 1);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      for (int c = 0; c < vecs[i].ncyc; c++) push_exp(vecs[i].hlen);
      pedal_en = vecs[i].en;
      cadence_per = vecs[i].per;
      if (vecs[i].ncyc == 0) begin
        repeat (300) @(negedge clk);
        check($sformatf("vec%0d_cadence", i), int'(cadence), 0);
        finish_idle($sformatf("vec%0d", i), 0);
      end else begin
        wait_rises($sformatf("vec%0d_timeout", i), vecs[i].ncyc,
                   vecs[i].ncyc * (2 * vecs[i].hlen + 200) + 10);
        repeat (10) @(negedge clk);
        pedal_en = 1'b0;
        repeat (2 * vecs[i].hlen + 200) @(negedge clk);
        finish_idle($sformatf("vec%0d", i), vecs[i].ncyc);
      end
    end

    // Period change mid-HIGH only applies to the next cycle
    do_reset();
    push_exp(1024);
    push_exp(512);
    pedal_en = 1'b1;
    cadence_per = 8'h10;
    repeat (100) @(negedge clk);
    cadence_per = 8'h08;
    wait_rises("perchg_timeout", 2, 2048 + 400);
    repeat (10) @(negedge clk);
    pedal_en = 1'b0;
    repeat (1024 + 200) @(negedge clk);
    finish_idle("perchg", 2);

    // Reset pulse mid-LOW aborts the cycle; full HIGH after release
    do_reset();
    pedal_en = 1'b1;
    cadence_per = 8'h10;
    wait_rises("rstlow_timeout", 1, 20);
    repeat (1024 + 300) @(negedge clk);
    check("rstlow_in_low", int'(pedaling && !cadence), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstlow_cadence", int'(cadence), 0);
    check("rstlow_pedaling", int'(pedaling), 0);
    rise_cnt = 0;
    lfsr_m = 8'hA5;
    push_exp(1024);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstlow_restart", int'(cadence_rise), 1);
    repeat (10) @(negedge clk);
    pedal_en = 1'b0;
    repeat (2048 + 200) @(negedge clk);
    finish_idle("rstlow", 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cadence_gen.md
CADENCE_GEN -- requirements
Module: cadence_gen

Interface
REQ-001 SHALL have parameter FAST_SIM, default 1, meaning period unit is 2^7 clk when 1 and 2^16 clk when 0 (SHIFT = 7 or 16).
REQ-002 SHALL have port clk, input, 1, sole system clock; all logic on posedge clk.
REQ-003 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-004 SHALL have port pedal_en, input, 1, request to generate cadence.
REQ-005 SHALL have port cadence_per, input, 8, target period in units of 2^SHIFT clk.
REQ-006 SHALL have port cadence, output, 1, registered square-wave cadence signal.
REQ-007 SHALL have port cadence_rise, output, 1, one-clk pulse coincident with each 0->1 of cadence.
REQ-008 SHALL have port pedaling, output, 1, high while state is not IDLE.

Function
REQ-009 SHALL implement FSM states IDLE, HIGH, LOW.
REQ-010 SHALL treat cadence_per as valid only when 8'h01 <= cadence_per < 8'hE4; 8'h00 and >= 8'hE4 mean not pedaling.
REQ-011 SHALL define go = pedal_en AND valid period.
REQ-012 IDLE: cadence=0; on a clk edge with go=1 -> HIGH, cadence=1 and cadence_rise=1 at that same edge (1-clk latency from go).
REQ-013 On each entry to HIGH, SHALL latch cadence_per into an internal period register; input changes during a cycle take effect only at the next rising edge.
REQ-014 Half-period length H = latched_per << (SHIFT-1) clk; 24-bit counter, no overflow possible.
REQ-015 HIGH lasts exactly H clk, then -> LOW with cadence=0.
REQ-016 LOW lasts exactly H clk (plus jitter term, REQ-025); at its end: if go -> HIGH (new rise, period relatched), else -> IDLE.
REQ-017 Deassertion of pedal_en or invalid period mid-cycle SHALL NOT truncate the current HIGH/LOW phases; the cycle completes and FSM returns to IDLE.
REQ-018 cadence_rise SHALL be high for exactly one clk per rising edge and never in LOW/IDLE.
REQ-019 Full period = 2*H clk, i.e. latched_per << SHIFT, matching the unit of the cadence measurement block so a measured period equals the commanded cadence_per.
REQ-020 pedaling SHALL be 0 in IDLE, 1 in HIGH and LOW.
REQ-021 All outputs SHALL be driven from flops (no combinational path from inputs to outputs).

Reset
REQ-022 When rst_n=0 at a clk edge: state=IDLE, cadence=0, cadence_rise=0, pedaling=0, counter=0, period register=0.
REQ-023 Reset asserted mid-HIGH or mid-LOW SHALL abort the cycle immediately; after release, a new cycle begins only on go, with full H high time.
REQ-024 With CADENCE_JITTER_EN defined, reset SHALL load the LFSR with 8'hA5.

Configuration
REQ-025 Macro CADENCE_JITTER_EN defined: 8-bit Fibonacci LFSR (taps 8,6,5,4) advances once per HIGH entry; LOW length = H + (lfsr[3:0] << (SHIFT-4)) clk; HIGH unchanged.
REQ-026 CADENCE_JITTER_EN undefined: no LFSR logic; LOW length exactly H.

Verification (FAST_SIM=1, jitter off unless stated)
REQ-027 Reset, pedal_en=1, cadence_per=8'h10 -> first rise 1 clk after go; cadence high 1024 clk, low 1024 clk; rises every 2048 clk.
REQ-028 cadence_per changed 8'h10->8'h08 mid-HIGH -> current cycle stays 2048 clk; next cycle 1024 clk (512/512).
REQ-029 pedal_en dropped 10 clk into HIGH of 8'h10 cycle -> high still 1024, low 1024, then IDLE, pedaling=0, no further rise.
REQ-030 cadence_per=8'hE4 or 8'h00 with pedal_en=1 from reset -> cadence stays 0, pedaling 0, no cadence_rise.
REQ-031 rst_n pulsed low mid-LOW -> next clk cadence=0, pedaling=0; after release with go, high time exactly 1024 clk.
REQ-032 CADENCE_JITTER_EN, cadence_per=8'h10 -> HIGH always 1024 clk; LOW in [1024,1144] clk, following LFSR sequence from seed 8'hA5.
